// File: rtl/lcd_cmd_issuer.sv
// ---------------------------------------------------------------------------
// lcd_cmd_issuer
//
// Host-side initiator for the LCD controller command interface. Host
// commands are buffered in a FIFO and handed to the controller one at a
// time, only while the controller reports not busy. After the terminating
// (write-back) opcode has been issued the block stops issuing and waits for
// the controller's done indication.
//
// Optional feature macro: ISSUE_TIMEOUT_EN
//   When defined, a watchdog counts stalled cycles (waiting on busy with work
//   queued, or waiting on done) and forces the sequence to finish after
//   TIMEOUT_CYC consecutive stalled cycles. When undefined, timeout_o is tied
//   low and the block waits for done indefinitely.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset          asynchronous, active-low reset
//   host_cmd_i     opcode to enqueue
//   host_valid_i   enqueue request (accepted when host_ready_o is high)
//   host_ready_o   FIFO not full
//   cmd_o          command to the LCD controller (holds last issued value)
//   cmd_valid_o    one-cycle issue strobe
//   busy_i         controller busy, nothing is issued while high
//   done_i         controller done
//   fifo_level_o   number of queued entries, 0..DEPTH
//   issued_cnt_o   commands issued since reset, saturating at 255
//   finished_o     sticky: done seen after the terminating opcode (or timeout)
//   proto_err_o    sticky: done seen while idle or in the guard cycle
//   timeout_o      sticky watchdog flag
// ---------------------------------------------------------------------------
module lcd_cmd_issuer #(
    parameter int         DEPTH       = 64,
    parameter int         ADDR_W      = 6,
    parameter logic [2:0] TERM_CMD    = 3'd0
`ifdef ISSUE_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [2:0]        host_cmd_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    output logic [2:0]        cmd_o,
    output logic              cmd_valid_o,
    input  logic              busy_i,
    input  logic              done_i,
    output logic [ADDR_W:0]   fifo_level_o,
    output logic [7:0]        issued_cnt_o,
    output logic              finished_o,
    output logic              proto_err_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        WAIT_DONE,
        FINISHED
    } state_e;

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   level_q, level_d;

    state_e            state_q;
    logic [2:0]        cmd_q;
    logic              cmdValid_q;
    logic [7:0]        issuedCnt_q;
    logic              finished_q;
    logic              protoErr_q;

    logic              push;
    logic              pop;

    // A full FIFO refuses the push even if the head is popped in the same
    // cycle; there is no empty bypass either, so a command always spends at
    // least one cycle in storage before it can be issued.
    assign host_ready_o = (level_q != LEVEL_FULL);
    assign push         = host_valid_i && host_ready_o;
    assign pop          = (state_q == IDLE) && !busy_i && (level_q != '0);

    // FIFO storage carries no reset; emptiness is tracked by the pointers
    // and level, so stale contents are simply never read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wrPtr_q] <= host_cmd_i;
        end
    end

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push) begin
            wrPtr_d = wrPtr_q + ADDR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (!push && pop) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

`ifdef ISSUE_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wdCnt_q;
    logic            timeout_q;
    logic            wdStall;
    logic            wdFire;

    // Stalled means: work is queued but the controller keeps us out, or we
    // are waiting for done. Any issue or state change breaks the stall.
    assign wdStall = ((state_q == IDLE) && busy_i && (level_q != '0)) ||
                     ((state_q == WAIT_DONE) && !done_i);
    assign wdFire  = wdStall && (wdCnt_q == WD_W'(TIMEOUT_CYC - 1));
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Issue sequencer. The guard cycle after each strobe ignores busy because
    // the controller only raises busy one cycle after sampling the command.
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmdValid_q  <= 1'b0;
            issuedCnt_q <= '0;
            finished_q  <= 1'b0;
            protoErr_q  <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
            wdCnt_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            cmdValid_q <= 1'b0;

            if (done_i && ((state_q == IDLE) || (state_q == GUARD))) begin
                protoErr_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cmd_q      <= mem[rdPtr_q];
                        cmdValid_q <= 1'b1;
                        if (issuedCnt_q != 8'hFF) begin
                            issuedCnt_q <= issuedCnt_q + 8'd1;
                        end
                        state_q <= GUARD;
                    end
                end
                GUARD: begin
                    state_q <= (cmd_q == TERM_CMD) ? WAIT_DONE : IDLE;
                end
                WAIT_DONE: begin
                    if (done_i) begin
                        finished_q <= 1'b1;
                        state_q    <= FINISHED;
                    end
                end
                FINISHED: begin
                    state_q <= FINISHED;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

`ifdef ISSUE_TIMEOUT_EN
            if (wdStall) begin
                wdCnt_q <= wdCnt_q + WD_W'(1);
            end else begin
                wdCnt_q <= '0;
            end
            if (wdFire) begin
                timeout_q  <= 1'b1;
                finished_q <= 1'b1;
                state_q    <= FINISHED;
                wdCnt_q    <= '0;
            end
`endif
        end
    end

    assign cmd_o        = cmd_q;
    assign cmd_valid_o  = cmdValid_q;
    assign fifo_level_o = level_q;
    assign issued_cnt_o = issuedCnt_q;
    assign finished_o   = finished_q;
    assign proto_err_o  = protoErr_q;

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_issuer
//
// Directed self-checking bench for lcd_cmd_issuer. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_issuer;

    localparam int DEPTH      = 64;
    localparam int ADDR_W     = 6;
    // Watchdog limit used when the optional feature is compiled in; kept
    // above the longest deliberate busy stall in the earlier scenarios.
    localparam int TB_TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       hostCmd;
    logic             hostValid;
    logic             hostReady;
    logic [2:0]       cmd;
    logic             cmdValid;
    logic             busy;
    logic             done;
    logic [ADDR_W:0]  fifoLevel;
    logic [7:0]       issuedCnt;
    logic             finished;
    logic             protoErr;
    logic             timeoutFlag;

    int checkCount = 0;
    int errorCount = 0;

    logic [2:0] t1Cmds [4];
    logic [7:0] t1Valid;
    int         issueIdx;
    int         pulses;
    int         orderErr;
    logic       expTimeout;

    always #5 clk = ~clk;

    lcd_cmd_issuer #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .TERM_CMD   (3'd0)
`ifdef ISSUE_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TB_TIMEOUT)
`endif
    ) dut (
        .clk_i        (clk),
        .reset        (reset),
        .host_cmd_i   (hostCmd),
        .host_valid_i (hostValid),
        .host_ready_o (hostReady),
        .cmd_o        (cmd),
        .cmd_valid_o  (cmdValid),
        .busy_i       (busy),
        .done_i       (done),
        .fifo_level_o (fifoLevel),
        .issued_cnt_o (issuedCnt),
        .finished_o   (finished),
        .proto_err_o  (protoErr),
        .timeout_o    (timeoutFlag)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic v,
                                 input logic b, input logic d);
        hostCmd   = c;
        hostValid = v;
        busy      = b;
        done      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("rst host_ready", hostReady, 1);
        checkOutput("rst cmd_valid", cmdValid, 0);
        checkOutput("rst cmd", cmd, 0);
        checkOutput("rst level", fifoLevel, 0);
        checkOutput("rst issued", issuedCnt, 0);
        checkOutput("rst finished", finished, 0);
        checkOutput("rst proto_err", protoErr, 0);
        checkOutput("rst timeout", timeoutFlag, 0);

        // Basic sequence 5,1,2,0 with busy low: strobes on edges 1,3,5,7.
        resetDut();
        t1Cmds  = '{3'd5, 3'd1, 3'd2, 3'd0};
        t1Valid = 8'b1010_1010;
        issueIdx = 0;
        for (int e = 0; e < 8; e++) begin
            if (e < 4) applyStimulus(t1Cmds[e], 1'b1, 1'b0, 1'b0);
            else       applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
            tick();
            checkOutput($sformatf("t1 valid e%0d", e), cmdValid, t1Valid[e]);
            if (t1Valid[e]) begin
                checkOutput($sformatf("t1 cmd #%0d", issueIdx), cmd, t1Cmds[issueIdx]);
                issueIdx++;
            end
        end
        checkOutput("t1 issued", issuedCnt, 4);
        checkOutput("t1 level", fifoLevel, 0);
        tick();
        tick();
        checkOutput("t1 waiting finished", finished, 0);
        checkOutput("t1 waiting valid", cmdValid, 0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1 finished", finished, 1);
        checkOutput("t1 no proto_err", protoErr, 0);
        // After finishing, pushes are stored but never issued.
        applyStimulus(3'd3, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmdValid) pulses++;
        end
        checkOutput("t1 finished no issue", pulses, 0);
        checkOutput("t1 finished level", fifoLevel, 1);
        checkOutput("t1 finished issued", issuedCnt, 4);

        // Busy held for 20 cycles with three entries queued.
        resetDut();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 3) applyStimulus(3'(i + 1), 1'b1, 1'b1, 1'b0);
            else       applyStimulus(3'd0, 1'b0, 1'b1, 1'b0);
            tick();
            if (cmdValid) pulses++;
        end
        checkOutput("t2 no issue while busy", pulses, 0);
        checkOutput("t2 level", fifoLevel, 3);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t2 valid after busy", cmdValid, 1);
        checkOutput("t2 cmd", cmd, 1);
        checkOutput("t2 level after issue", fifoLevel, 2);

        // done pulsed while idle: flagged, but sequencing is unaffected.
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("t4 proto_err before", protoErr, 0);
        applyStimulus(3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("t4 proto_err", protoErr, 1);
        checkOutput("t4 finished", finished, 0);
        checkOutput("t4 valid held off", cmdValid, 0);
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t4 valid continues", cmdValid, 1);
        checkOutput("t4 cmd", cmd, 2);
        checkOutput("t4 issued", issuedCnt, 2);

        // Fill to DEPTH, then a push during the first pop is refused.
        resetDut();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(3'(1 + i % 7), 1'b1, 1'b1, 1'b0);
            tick();
        end
        checkOutput("t3 full level", fifoLevel, DEPTH);
        checkOutput("t3 full ready", hostReady, 0);
        applyStimulus(3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("t3 level after pop", fifoLevel, DEPTH - 1);
        checkOutput("t3 first valid", cmdValid, 1);
        checkOutput("t3 first cmd", cmd, 1);
        issueIdx = 1;
        orderErr = 0;
        for (int c = 0; c < 300 && issueIdx < DEPTH; c++) begin
            tick();
            if (cmdValid) begin
                if (cmd !== 3'(1 + issueIdx % 7)) orderErr++;
                issueIdx++;
            end
        end
        checkOutput("t3 drained count", issueIdx, DEPTH);
        checkOutput("t3 drain order", orderErr, 0);
        checkOutput("t3 drained level", fifoLevel, 0);
        checkOutput("t3 issued", issuedCnt, DEPTH);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmdValid) pulses++;
        end
        checkOutput("t3 rejected not stored", pulses, 0);
        // Pointers have wrapped; a fresh entry still comes out correctly.
        applyStimulus(3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t3 wrap valid", cmdValid, 1);
        checkOutput("t3 wrap cmd", cmd, 6);
        checkOutput("t3 wrap issued", issuedCnt, DEPTH + 1);

        // Reset asserted during the strobe cycle.
        resetDut();
        applyStimulus(3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t5 valid before reset", cmdValid, 1);
        reset = 1'b0;
        #1;
        checkOutput("t5 valid async drop", cmdValid, 0);
        checkOutput("t5 level cleared", fifoLevel, 0);
        checkOutput("t5 issued cleared", issuedCnt, 0);
        tick();
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmdValid) pulses++;
        end
        checkOutput("t5 contents discarded", pulses, 0);
        checkOutput("t5 level after release", fifoLevel, 0);

        // Terminating command issued, done never arrives.
        resetDut();
        applyStimulus(3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t6 term valid", cmdValid, 1);
        checkOutput("t6 term cmd", cmd, 0);
        tick();
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        checkOutput("t6 timeout early", timeoutFlag, 0);
        checkOutput("t6 finished early", finished, 0);
        tick();
`ifdef ISSUE_TIMEOUT_EN
        expTimeout = 1'b1;
`else
        expTimeout = 1'b0;
`endif
        checkOutput("t6 timeout", timeoutFlag, expTimeout);
        checkOutput("t6 finished", finished, expTimeout);
        for (int i = 0; i < 20; i++) tick();
        checkOutput("t6 finished later", finished, expTimeout);
        checkOutput("t6 no further valid", cmdValid, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
